itof: RTL and testbench
=======================

# itof

Pipelined signed 32-bit integer to IEEE-754 binary32 converter for the FPU datapath. It is the inverse companion of the float-to-int stage: it feeds converted operands into the float pipeline, and its output can be looped straight into the float-to-int stage for round-trip checks. It uses three register stages and a valid/ready handshake with a global stall. Rounding is round-to-nearest-even.

## Interface
- No parameters; widths fixed: int32 in, binary32 out.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  x carries a new operand
- in_ready  out  1  converter accepts x this cycle
- x  in  32  two's-complement integer
- out_valid  out  1  y holds a result
- out_ready  in  1  consumer takes y this cycle
- y  out  32  binary32 result {sign, exp[7:0], frac[22:0]}

## Operation
- Global enable: en = !v3 | out_ready, where v3 is the stage-3 valid bit. in_ready = en. An input transfer happens when in_valid & in_ready; an output transfer happens when out_valid & out_ready.
- Stage 1 (on en):
  - v1 <= in_valid; s1 <= x[31].
  - a1 <= s1 ? (~x + 1) : x, computed unsigned 32-bit.
  - x = 0x80000000 yields a1 = 0x80000000, which is correct as an unsigned magnitude.
- Stage 2 (on en): v2 <= v1; s2 <= s1; z2 <= (a1 == 0); lz2 <= leading-zero count of a1 (0..31); n2 <= a1 << lz2, so the MSB is 1 unless zero.
- Stage 3 (on en): v3 <= v2; compute y.
  - Mantissa m = n2[31:8] (24 bits including the hidden 1).
  - Rounding bits: guard g = n2[7]; sticky st = |n2[6:0].
  - Round up when g & (st | m[0]).
  - Sum mr = m + roundup, 25 bits wide.
  - Exponent e = 158 − lz2, plus 1 if mr[24] (carry out). The fraction is then mr[23:1], which equals 0.
  - Otherwise the fraction is mr[22:0].
  - Output y = {s2, e[7:0], frac}.
  - If z2, y = 0x00000000. There is no −0.
  - Overflow, NaN and denormals are impossible for int32 input; max e = 158.
- out_valid = v3. While en = 0, all stage registers, including data, hold.
- Data registers may update with don't-care contents when their valid bit is 0. Only y qualified by out_valid is checked.

## Timing
- Latency: 3 accepted clock edges from the input transfer to out_valid. Throughput is 1 result per cycle while out_ready = 1.
- Reset (async assert, sync release): v1, v2, v3 = 0 and y = 0. Therefore out_valid = 0 and in_ready = 1 from reset onward.
- Stall: with out_valid = 1 and out_ready = 0, in_ready drops in the same cycle (combinational). y and out_valid stay stable until the transfer.
- Bubbles are not squeezed out: when v3 = 1 and the output stalls, the whole pipe freezes even if v1 or v2 = 0.
- Simultaneous input and output transfer in one cycle is legal and preserves full throughput.
- Reset asserted mid-operation discards all in-flight operands immediately. No result appears for them.
- Combinational path out_ready → in_ready is accepted. No skid buffer.

## Structure
- fpu_pkg holds:
  - F32_BIAS = 127
  - F32_EXP_W = 8, F32_FRAC_W = 23
  - typedef struct packed {sign, exp, frac} f32_t, shared with the other FPU blocks, including float-to-int.
- Sub-module lzc32: combinational 32-bit leading-zero counter, output 5 bits plus an all-zero flag. It is instantiated in stage 2 and reusable by the add/sub normaliser.
- Expected size is about 150–250 lines, including lzc32.

## Test plan
- Basic values with out_ready = 1 and back-to-back input:
  - 3 → 0x40400000
  - −3 (0xFFFFFFFD) → 0xC0400000
  - 0 → 0x00000000
  - 1 → 0x3F800000
  - Each result must appear exactly 3 cycles after its input transfer.
- Rounding to nearest even:
  - 16777217 (0x01000001) → 0x4B800000 (tie, rounds down to even)
  - 16777219 (0x01000003) → 0x4B800002 (tie, rounds up)
  - 1000000001 → 0x4E6E6B28
- Extremes:
  - 0x7FFFFFFF → 0x4F000000 (mantissa carry bumps the exponent)
  - 0x80000000 → 0xCF000000
  - 0xFFFFFFFF → 0xBF800000
- Backpressure: stream 8 values and hold out_ready = 0 for 5 cycles while out_valid = 1. Required:
  - in_ready = 0 throughout the hold.
  - y stays stable throughout the hold.
  - No result is lost or duplicated, and order is preserved.
- Reset mid-stream: assert rstn = 0 with 3 operands in flight. Required:
  - out_valid = 0 and y = 0 asynchronously.
  - After release, in_ready = 1.
  - The first result seen is for the first post-reset input.
- Round-trip: random int32 values in ±2^24 fed through itof then float-to-int must return the original integer.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and types shared by the FPU datapath blocks
// (itof, float-to-int, add/sub normaliser).
//   F32_BIAS      binary32 exponent bias
//   F32_EXP_W     exponent field width
//   F32_FRAC_W    stored fraction width (hidden bit excluded)
//   F32_ITOF_EMAX biased exponent for a value in [2^31, 2^32)
//   f32_t         packed binary32 word {sign, exp, frac}
package fpu_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_EXP_W  = 8;
  localparam int F32_FRAC_W = 23;

  // An int32 magnitude has at most 32 significant bits, so its MSB weight
  // is at most 2^31 and the biased exponent never exceeds bias + 31.
  localparam logic [F32_EXP_W-1:0] F32_ITOF_EMAX = 8'(F32_BIAS + 31);

  typedef struct packed {
    logic                  sign;
    logic [F32_EXP_W-1:0]  exp;
    logic [F32_FRAC_W-1:0] frac;
  } f32_t;

endpackage

// File: rtl/itof_if.sv
// itof_if: handshake bundle around the int-to-float converter.
//   in_valid / in_ready / x    : operand input channel
//   out_valid / out_ready / y  : binary32 result channel
//   modport slave  : the converter side
//   modport master : the producer/consumer side driving the converter
interface itof_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y
  );

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );

endinterface

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
//   a     in  32  value to scan
//   count out 5   number of zeros above the most significant 1 (0..31)
//   zero  out 1   a is all zeros (count is then meaningless)
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  count,
  output logic        zero
);

  // Scan from LSB to MSB so the highest set bit is the last one to write
  // the count; that leaves a plain priority chain with no early exit.
  always_comb begin
    count = '0;
    zero  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) begin
        count = 5'(31 - i);
        zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/itof.sv
// itof: three-stage pipelined signed int32 -> IEEE-754 binary32 converter,
// round-to-nearest-even, valid/ready handshake with a single global stall.
//   clk   in  rising-edge clock
//   rstn  in  asynchronous active-low reset
//   bus   itof_if.slave: in_valid/in_ready/x in, out_valid/out_ready/y out
// Stage 1 takes the magnitude, stage 2 normalises it so bit 31 is the
// leading one, stage 3 rounds and packs the result register.
module itof
  import fpu_pkg::*;
(
  input logic   clk,
  input logic   rstn,
  itof_if.slave bus
);

  logic        en;

  logic        v1;
  logic        s1;
  logic [31:0] a1;

  logic        v2;
  logic        s2;
  logic        z2;
  logic [4:0]  lz2;
  logic [31:0] n2;

  logic        v3;
  f32_t        y_q;
  f32_t        y_d;

  logic [4:0]  lz_a1;
  logic        zero_a1;

  logic [23:0] m;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [24:0] mr;
  logic [7:0]  e;

  // The whole pipe advances together; it only freezes when a finished
  // result is sitting in stage 3 and nobody takes it. Bubbles in stages
  // 1/2 are deliberately not squeezed out.
  assign en            = !v3 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.y         = y_q;

  lzc32 u_lzc (
    .a     (a1),
    .count (lz_a1),
    .zero  (zero_a1)
  );

  // Stage 1: capture the sign and the unsigned magnitude. 0x80000000
  // negates to itself, which is exactly the right unsigned magnitude.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      a1 <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      s1 <= bus.x[31];
      a1 <= bus.x[31] ? (~bus.x + 32'd1) : bus.x;
    end
  end

  // Stage 2: normalise so the leading one lands in bit 31.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2  <= 1'b0;
      s2  <= 1'b0;
      z2  <= 1'b1;
      lz2 <= '0;
      n2  <= '0;
    end else if (en) begin
      v2  <= v1;
      s2  <= s1;
      z2  <= zero_a1;
      lz2 <= lz_a1;
      n2  <= a1 << lz_a1;
    end
  end

  // Stage 3 datapath: keep 24 bits (hidden one included), round to
  // nearest even on the guard bit plus sticky of everything below it.
  // A carry out of the mantissa means the value became a power of two,
  // so the exponent bumps by one and the fraction is all zeros.
  always_comb begin
    m        = n2[31:8];
    guard    = n2[7];
    sticky   = |n2[6:0];
    round_up = guard & (sticky | m[0]);
    mr       = {1'b0, m} + {24'd0, round_up};
    e        = F32_ITOF_EMAX - {3'd0, lz2} + {7'd0, mr[24]};
    y_d      = '0;
    if (!z2) begin
      y_d.sign = s2;
      y_d.exp  = e;
      y_d.frac = mr[24] ? mr[23:1] : mr[22:0];
    end
  end

  // Stage 3 register: the result held on the output until it is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3  <= 1'b0;
      y_q <= '0;
    end else if (en) begin
      v3  <= v2;
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_itof.sv
// tb_itof: scoreboard bench for itof. Stimulus pushes the reference result
// of every accepted operand into a queue; a negedge monitor pops and
// compares whenever a result transfer happens, and also checks latency in
// accepted (enabled) clock edges. Inputs change only shortly after posedge.
module tb_itof;

  logic clk;
  logic rstn;

  itof_if bus ();

  itof dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] y;
    logic [31:0] x;
    int          tag;
    bit          rt;
  } exp_t;

  exp_t        expq[$];
  int          checks;
  int          passed;
  int          en_count;
  bit          rt_mode;
  logic [31:0] held_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion from the arithmetic definition: find the MSB
  // position, scale the magnitude to 24 significant bits, round the
  // discarded remainder to nearest with ties to even.
  function automatic logic [31:0] refModel(input logic [31:0] v);
    longint mag;
    longint q;
    longint r;
    longint half;
    int     e;
    int     sh;
    logic   sgn;
    logic [31:0] res;
    if (v == 32'd0) return 32'd0;
    sgn = v[31];
    mag = sgn ? (64'sh1_0000_0000 - longint'({32'd0, v})) : longint'({32'd0, v});
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      r    = mag - (q << sh);
      half = 64'sd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'sd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    res = {sgn, 8'(e + 127), q[22:0]};
    return res;
  endfunction

  // Behavioural float-to-int for exactly representable values.
  function automatic logic [31:0] floatToInt(input logic [31:0] f);
    longint mant;
    longint val;
    int     e;
    if (f[30:23] == 8'd0) return 32'd0;
    e    = int'(f[30:23]) - 127;
    mant = longint'({41'd0, 1'b1, f[22:0]});
    val  = (e >= 23) ? (mant << (e - 23)) : (mant >> (23 - e));
    if (f[31]) val = -val;
    return 32'(val);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Present one operand and hold it until the converter accepts it; if the
  // output is stalling, release the consumer so the pipe can drain.
  task automatic applyStimulus(input logic [31:0] v);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.x        = v;
    #1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (bus.in_ready) begin
        done = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: results are compared in the order their operands were taken,
  // and must show up exactly three enabled edges after acceptance.
  always @(negedge clk) begin
    exp_t ex;
    if (!rstn) begin
      expq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", bus.y, 32'hxxxx_xxxx);
        end else begin
          ex = expq.pop_front();
          checkOutput("result", bus.y, ex.y);
          checkOutput("latency", 32'(en_count - ex.tag), 32'd3);
          if (ex.rt) checkOutput("roundtrip", floatToInt(bus.y), ex.x);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        ex.y   = refModel(bus.x);
        ex.x   = bus.x;
        ex.tag = en_count;
        ex.rt  = rt_mode;
        expq.push_back(ex);
      end
      if (bus.in_ready) en_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fixed [11];
    logic [31:0] bp [8];
    int          rv;

    checks        = 0;
    passed        = 0;
    en_count      = 0;
    rt_mode       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b1;
    rstn          = 1'b1;
    #1 rstn = 1'b0;
    #2;
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_y", bus.y, 32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, back to back with the consumer always ready.
    fixed = '{32'd3, 32'hFFFF_FFFD, 32'd0, 32'd1,
              32'h0100_0001, 32'h0100_0003, 32'd1000000001,
              32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd16777216};
    foreach (fixed[i]) applyStimulus(fixed[i]);
    idle(6);
    // Spot-check the reference model against hand-derived encodings.
    checkOutput("ref_3", refModel(fixed[0]), 32'h4040_0000);
    checkOutput("ref_m3", refModel(fixed[1]), 32'hC040_0000);
    checkOutput("ref_tie_down", refModel(fixed[4]), 32'h4B80_0000);
    checkOutput("ref_tie_up", refModel(fixed[5]), 32'h4B80_0002);
    checkOutput("ref_1e9", refModel(fixed[6]), 32'h4E6E_6B28);
    checkOutput("ref_maxpos", refModel(fixed[7]), 32'h4F00_0000);
    checkOutput("ref_minneg", refModel(fixed[8]), 32'hCF00_0000);
    checkOutput("ref_m1", refModel(fixed[9]), 32'hBF80_0000);

    // Backpressure: fill the pipe, then stall the consumer for 5 cycles.
    foreach (bp[i]) bp[i] = $urandom();
    for (int i = 0; i < 3; i++) applyStimulus(bp[i]);
    bus.in_valid  = 1'b1;
    bus.x         = bp[3];
    bus.out_ready = 1'b0;
    #1;
    held_y = bus.y;
    repeat (5) begin
      checkOutput("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      checkOutput("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("hold_y_stable", bus.y, held_y);
      @(posedge clk);
      #2;
    end
    bus.out_ready = 1'b1;
    for (int i = 3; i < 8; i++) applyStimulus(bp[i]);
    idle(6);

    // Reset with three operands in flight; none of them may surface.
    for (int i = 0; i < 3; i++) applyStimulus($urandom());
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("midreset_y", bus.y, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    checkOutput("postreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(32'd5);
    applyStimulus(32'hFFFF_FF00);
    idle(6);

    // Random full-range operands with random gaps and consumer stalls.
    for (int i = 0; i < 60; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      applyStimulus($urandom());
    end
    bus.out_ready = 1'b1;
    idle(6);

    // Round-trip through the float-to-int model for values within +-2^24.
    rt_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rv = int'($urandom_range(0, 33554432)) - 16777216;
      bus.out_ready = ($urandom_range(0, 4) != 0);
      applyStimulus(32'(rv));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;

    for (int n = 0; n < 50 && expq.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
